onchip_ram_arbiter: RTL and testbench

- Shares the single-port 32-bit on-chip RAM (15-bit word address, 4 byte lanes, 1-cycle read latency) between two Avalon-MM masters: m0 (CPU data port) and m1 (DMA).
- Round-robin arbitration, at most one access issued per cycle.
- Per-master waitrequest and readdatavalid handshake.
- Drives the RAM's address, byteenable, chipselect, write, writedata and clken pins directly.

---
 rtl/onchip_ram_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/onchip_ram_arbiter.sv | 125 ++++++++++++
 tb/tb_onchip_ram_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared constants and types for the on-chip RAM arbitration slice.
package onchip_ram_pkg;

  localparam int RAM_ADDR_W     = 15;
  localparam int RAM_DATA_W     = 32;
  localparam int RAM_BE_W       = 4;
  localparam int RAM_RD_LATENCY = 1;
  localparam int NUM_MASTERS    = 2;

  typedef logic [0:0] master_idx_t;

  // With two masters the "next in line" is simply the other one.
  function automatic master_idx_t other_master(input master_idx_t k);
    return ~k;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: same-cycle grant, priority pointer moves past each winner.
module rr_arbiter2
  import onchip_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pause,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  master_idx_t prio_reg;
  master_idx_t winner;

  always_comb begin
    grant = 2'b00;
    if (!pause) begin
      if (req == 2'b11) begin
        grant[prio_reg] = 1'b1;
      end else begin
        grant = req;
      end
    end
  end

  assign winner = master_idx_t'(grant[1]);

  // A cycle without a grant leaves the pointer where it was.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_reg <= '0;
    end else if (|grant) begin
      prio_reg <= other_master(winner);
    end
  end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters with round-robin grants.
module onchip_ram_arbiter
  import onchip_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int BE_W   = RAM_BE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pause,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              proto_err
);

  logic [ADDR_W-1:0] addr_arr [NUM_MASTERS];
  logic [BE_W-1:0]   be_arr   [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr[NUM_MASTERS];
  logic [1:0]        rd_req;
  logic [1:0]        wr_req;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic [1:0]        wait_vec;
  logic [1:0]        rdv_vec;
  logic              gnt_any;
  master_idx_t       gnt_idx;

  logic              rd_pend_reg;
  master_idx_t       rd_owner_reg;
  logic              proto_err_reg;

  assign addr_arr[0]  = m0_address;
  assign addr_arr[1]  = m1_address;
  assign be_arr[0]    = m0_byteenable;
  assign be_arr[1]    = m1_byteenable;
  assign wdata_arr[0] = m0_writedata;
  assign wdata_arr[1] = m1_writedata;
  assign rd_req       = {m1_read, m0_read};
  assign wr_req       = {m1_write, m0_write};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .pause   (pause),
    .req     (req),
    .grant   (grant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign req[gi]      = rd_req[gi] | wr_req[gi];
      assign wait_vec[gi] = req[gi] & ~grant[gi];
      assign rdv_vec[gi]  = rd_pend_reg & (rd_owner_reg == master_idx_t'(gi));
    end
  endgenerate

  assign gnt_any = |grant;
  assign gnt_idx = master_idx_t'(grant[1]);

  // Idle RAM bus is driven to zero rather than left following a master.
  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    ram_write      = 1'b0;
    if (gnt_any) begin
      ram_address    = addr_arr[gnt_idx];
      ram_byteenable = be_arr[gnt_idx];
      ram_writedata  = wdata_arr[gnt_idx];
      ram_write      = wr_req[gnt_idx];
    end
  end

  assign ram_chipselect = gnt_any;
  assign ram_clken      = 1'b1;

  // Read+write together is executed as a write; only a pure read expects data back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_reg   <= 1'b0;
      rd_owner_reg  <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      rd_pend_reg <= gnt_any & rd_req[gnt_idx] & ~wr_req[gnt_idx];
      if (gnt_any) begin
        rd_owner_reg <= gnt_idx;
      end
      if (gnt_any & rd_req[gnt_idx] & wr_req[gnt_idx]) begin
        proto_err_reg <= 1'b1;
      end
    end
  end

  assign m0_waitrequest   = wait_vec[0];
  assign m1_waitrequest   = wait_vec[1];
  assign m0_readdatavalid = rdv_vec[0];
  assign m1_readdatavalid = rdv_vec[1];
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign proto_err        = proto_err_reg;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed plus randomized bench for onchip_ram_arbiter against a transaction-level reference model.
module tb_onchip_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pause = 1'b0;
  logic [14:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [14:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = '0;
  logic        proto_err;

  onchip_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .pause(pause),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_writedata(ram_writedata),
    .ram_clken(ram_clken), .ram_readdata(ram_readdata), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  bit [31:0] ram_mem [0:32767];
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  // Reference model state
  bit [31:0] ref_mem [0:32767];
  int        m_prio;
  bit        m_pend;
  int        m_owner;
  bit [31:0] m_data;
  bit        m_proto;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic        s_wait0, s_wait1, s_rdv0, s_rdv1, s_cs, s_proto;
  logic [31:0] s_rd0, s_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_pend = 0; m_owner = 0; m_proto = 0;
  endtask

  task automatic poke(input int a, input bit [31:0] v);
    ram_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic set_m(input int k, input bit r, input bit w, input bit [14:0] a,
                       input bit [3:0] be, input bit [31:0] d);
    if (k == 0) begin
      m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic idle_all();
    pause = 1'b0;
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle: predict, sample at mid-cycle, compare, then advance the model at the edge.
  task automatic cycle();
    bit          r[2], w[2], rq[2];
    bit [14:0]   a[2];
    bit [3:0]    be[2];
    bit [31:0]   d[2];
    int          g;
    r[0] = m0_read; w[0] = m0_write; a[0] = m0_address; be[0] = m0_byteenable; d[0] = m0_writedata;
    r[1] = m1_read; w[1] = m1_write; a[1] = m1_address; be[1] = m1_byteenable; d[1] = m1_writedata;
    rq[0] = r[0] | w[0];
    rq[1] = r[1] | w[1];
    g = -1;
    if (!pause) begin
      if (rq[0] && rq[1]) g = m_prio;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
    end
    #4;
    s_wait0 = m0_waitrequest; s_wait1 = m1_waitrequest;
    s_rdv0 = m0_readdatavalid; s_rdv1 = m1_readdatavalid;
    s_rd0 = m0_readdata; s_rd1 = m1_readdata;
    s_cs = ram_chipselect; s_proto = proto_err;
    chk("wait0", 32'(s_wait0), 32'(rq[0] && g != 0));
    chk("wait1", 32'(s_wait1), 32'(rq[1] && g != 1));
    chk("chipselect", 32'(s_cs), 32'(g >= 0));
    chk("clken", 32'(ram_clken), 32'd1);
    chk("ram_write", 32'(ram_write), 32'(g >= 0 && w[g]));
    chk("ram_address", 32'(ram_address), (g >= 0) ? 32'(a[g]) : 32'd0);
    chk("ram_be", 32'(ram_byteenable), (g >= 0) ? 32'(be[g]) : 32'd0);
    chk("ram_wdata", ram_writedata, (g >= 0) ? d[g] : 32'd0);
    chk("rdv0", 32'(s_rdv0), 32'(m_pend && m_owner == 0));
    chk("rdv1", 32'(s_rdv1), 32'(m_pend && m_owner == 1));
    if (m_pend) begin
      chk("rdata0", s_rd0, m_data);
      chk("rdata1", s_rd1, m_data);
    end
    chk("proto_err", 32'(s_proto), 32'(m_proto));
    if (g >= 0)
      $display("t=%0t grant m%0d %s addr=%h be=%h wdata=%h", $time, g,
               w[g] ? (r[g] ? "rd+wr" : "write") : "read", a[g], be[g], d[g]);
    @(posedge clk);
    m_pend = 0;
    if (g >= 0) begin
      m_prio = 1 - g;
      if (w[g]) begin
        for (int b = 0; b < 4; b++)
          if (be[g][b]) ref_mem[a[g]][8*b +: 8] = d[g][8*b +: 8];
        if (r[g]) m_proto = 1;
      end else begin
        m_pend  = 1;
        m_owner = g;
        m_data  = ref_mem[a[g]];
      end
    end
    #1;
  endtask

  initial begin
    int strobes;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdv0", 32'(m0_readdatavalid), 32'd0);
    chk("reset_rdv1", 32'(m1_readdatavalid), 32'd0);
    chk("reset_proto", 32'(proto_err), 32'd0);
    reset_n = 1'b1;
    cycle();

    // Single-master read
    poke(15'h0010, 32'hDEADBEEF);
    set_m(0, 1, 0, 15'h0010, 4'hF, 0);
    cycle();
    chk("single_wait0", 32'(s_wait0), 32'd0);
    idle_all();
    cycle();
    chk("single_rdv0", 32'(s_rdv0), 32'd1);
    chk("single_rdata", s_rd0, 32'hDEADBEEF);
    chk("single_rdv1", 32'(s_rdv1), 32'd0);

    // Contention straight out of reset
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) poke(32 + i, 32'hA000_0000 + i);
    strobes = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        set_m(0, 1, 0, 15'(32 + i), 4'hF, 0);
        set_m(1, 1, 0, 15'(40 + i), 4'hF, 0);
      end else idle_all();
      cycle();
      if (i < 6) chk("cont_wait0", 32'(s_wait0), 32'(i % 2));
      if (i > 0) begin
        chk("cont_owner0", 32'(s_rdv0), 32'((i - 1) % 2 == 0));
        strobes += int'(s_rdv0) + int'(s_rdv1);
      end
    end
    chk("cont_strobes", 32'(strobes), 32'd6);

    // Byte-lane write by m1, read back by m0
    poke(15'h7FFF, 32'h11223344);
    set_m(1, 0, 1, 15'h7FFF, 4'b0100, 32'h00AB0000);
    cycle();
    idle_all();
    set_m(0, 1, 0, 15'h7FFF, 4'hF, 0);
    cycle();
    idle_all();
    cycle();
    chk("byte_rdata", s_rd0, 32'h11AB3344);

    // Pause with a read in flight
    set_m(0, 1, 0, 15'h0010, 4'hF, 0);
    cycle();
    pause = 1'b1;
    set_m(1, 1, 0, 15'h0020, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("pause_cs", 32'(s_cs), 32'd0);
      chk("pause_wait", 32'({s_wait1, s_wait0}), 32'd3);
      if (i == 0) chk("pause_rdv0", 32'(s_rdv0), 32'd1);
    end
    pause = 1'b0;
    cycle();
    chk("pause_prio_m1", 32'({s_wait1, s_wait0}), 32'b01);
    idle_all();
    cycle();

    // Read and write together
    set_m(0, 1, 1, 15'h0002, 4'hF, 32'h5);
    cycle();
    idle_all();
    cycle();
    chk("proto_no_rdv", 32'({s_rdv1, s_rdv0}), 32'd0);
    chk("proto_set", 32'(s_proto), 32'd1);
    set_m(1, 1, 0, 15'h0002, 4'hF, 0);
    cycle();
    idle_all();
    repeat (3) cycle();
    chk("proto_wdata", 32'(ram_mem[2]), 32'h5);
    chk("proto_sticky", 32'(s_proto), 32'd1);

    // Reset with a read in flight
    set_m(1, 1, 0, 15'h0010, 4'hF, 0);
    cycle();
    idle_all();
    chk("rst_inflight", 32'(m1_readdatavalid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    set_m(0, 1, 0, 15'h0003, 4'hF, 0);
    set_m(1, 1, 0, 15'h0004, 4'hF, 0);
    cycle();
    chk("rst_first_m0", 32'({s_wait1, s_wait0}), 32'b10);
    idle_all();
    cycle();

    // Randomized traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      pause = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 2; k++) begin
        int sel;
        sel = $urandom_range(0, 39);
        set_m(k, (sel >= 16 && sel < 28) || sel == 39, sel >= 28,
              15'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      end
      cycle();
    end
    idle_all();
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
